// File: rtl/anim_sound_pkg.sv
// Shared types and default sizing for the animation sound playback scheduler.
package anim_sound_pkg;

    localparam int N_CLIPS_DEF  = 4;
    localparam int ADDR_W_DEF   = 15;
    localparam int DATA_W_DEF   = 24;
    localparam int CLIP_LEN_DEF = 24000;

    localparam int CLIP_IDX_W = (N_CLIPS_DEF > 1) ? $clog2(N_CLIPS_DEF) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } sched_state_e;

    typedef logic [CLIP_IDX_W-1:0] clip_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int off = 0; off < N; off++) begin
            // ptr_i < N and off < N, so one subtraction is enough to wrap
            k = int'(ptr_i) + off;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid_o && req_i[k]) begin
                valid_o    = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/animation_sound_sched.sv
// Round-robin playback scheduler: latches clip play requests, walks the shared
// ROM address for the granted clip and streams samples to the codec.
module animation_sound_sched
    import anim_sound_pkg::*;
#(
    parameter  int N_CLIPS  = N_CLIPS_DEF,
    parameter  int ADDR_W   = ADDR_W_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int CLIP_LEN = CLIP_LEN_DEF,
    localparam int IDX_W    = (N_CLIPS > 1) ? $clog2(N_CLIPS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIPS-1:0]          req,
    input  logic                        stop,
    input  logic                        write_ready,
    input  logic [N_CLIPS*DATA_W-1:0]   rom_q,
    output logic [ADDR_W-1:0]           rom_address,
    output logic                        audio_write,
    output logic [DATA_W-1:0]           wdata_left,
    output logic [DATA_W-1:0]           wdata_right,
    output logic [IDX_W-1:0]            active_clip,
    output logic                        busy,
    output logic                        done,
    output logic [N_CLIPS-1:0]          pending,
    output sched_state_e                state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLIP_LEN - 1);

    sched_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [N_CLIPS-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   active_q, active_d;
    logic               done_q, done_d;

    logic [N_CLIPS-1:0] arb_grant;
    logic [N_CLIPS-1:0] grant_mask;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [DATA_W-1:0]  sample;

    rr_arbiter #(.N(N_CLIPS)) u_arb (
        .req_i   (pending_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            active_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rr_ptr_d    = rr_ptr_q;
        active_d    = active_q;
        done_d      = 1'b0;
        grant_mask  = '0;
        audio_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_mask = arb_grant;
                    active_d   = arb_idx;
                    addr_d     = '0;
                    rr_ptr_d   = (arb_idx == IDX_W'(N_CLIPS - 1)) ? '0 : arb_idx + IDX_W'(1);
                    state_d    = PLAY;
                end
            end
            PLAY: begin
                // Handshake: a sample moves when audio_write and write_ready are both high;
                // stop suppresses the write in its own cycle and beats a final accept.
                audio_write = ~stop;
                if (stop) begin
                    state_d = IDLE;
                end else if (write_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        addr_d  = '0;
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q | req) & ~grant_mask;
    end

    // Presenting the next address keeps the 1-cycle ROM in step with accepts.
    assign rom_address = addr_d;
    assign sample      = rom_q[active_q*DATA_W +: DATA_W];
    assign wdata_left  = audio_write ? sample : '0;
    assign wdata_right = wdata_left;
    assign active_clip = active_q;
    assign busy        = (state_q == PLAY);
    assign done        = done_q;
    assign pending     = pending_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_animation_sound_sched.sv
// Directed bench for animation_sound_sched with 8-sample clips; clip i word k = i*256+k.
module tb_animation_sound_sched;
    import anim_sound_pkg::*;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int DW = 24;
    localparam int CL = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic            stop;
    logic            write_ready;
    logic [N*DW-1:0] rom_q;
    logic [AW-1:0]   rom_address;
    logic            audio_write;
    logic [DW-1:0]   wdata_left;
    logic [DW-1:0]   wdata_right;
    logic [1:0]      active_clip;
    logic            busy;
    logic            done;
    logic [N-1:0]    pending;
    sched_state_e    state_dbg;

    animation_sound_sched #(.N_CLIPS(N), .ADDR_W(AW), .DATA_W(DW), .CLIP_LEN(CL)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .stop        (stop),
        .write_ready (write_ready),
        .rom_q       (rom_q),
        .rom_address (rom_address),
        .audio_write (audio_write),
        .wdata_left  (wdata_left),
        .wdata_right (wdata_right),
        .active_clip (active_clip),
        .busy        (busy),
        .done        (done),
        .pending     (pending),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural 1-cycle synchronous clip ROMs
    for (genvar gi = 0; gi < N; gi++) begin : g_rom
        always @(posedge clk) rom_q[gi*DW +: DW] <= DW'(gi * 256) + DW'(rom_address);
    end

    // scoreboard
    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    typedef struct {
        logic [N-1:0]  req;
        logic          stop;
        logic          wr;
        logic          aw;
        logic [DW-1:0] data;
        logic          busy;
        logic          done;
        logic [N-1:0]  pend;
        logic [AW-1:0] addr;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // one clock: monitor at negedge, return at posedge+1 ready for new inputs
    task automatic cycle();
        @(negedge clk);
        if (!reset) begin
            if (audio_write) chk("wdata_right_eq_left", 64'(wdata_right), 64'(wdata_left));
            else             chk("wdata_zero_no_write", 64'(wdata_left), 64'd0);
            if (prev_hold && audio_write) chk("held_sample", 64'(wdata_left), 64'(prev_data));
            if (audio_write && write_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write got=%0h exp=none at %0t", wdata_left, $time);
                end else begin
                    chk("sample", 64'(wdata_left), 64'(exp_q.pop_front()));
                end
                wr_cnt++;
            end
            if (done) done_cnt++;
            prev_hold = audio_write && !write_ready;
            prev_data = wdata_left;
        end else begin
            prev_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; stop = 1'b0; write_ready = 1'b1;
        exp_q.delete();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push_clip(input int clip, input int first, input int count);
        for (int k = first; k < first + count; k++) exp_q.push_back(DW'(clip * 256 + k));
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            cycle();
            n++;
        end
        if (done_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=%0d exp=%0d", name, done_cnt, target);
        end
    endtask

    initial begin
        int d0;
        int w0;
        int n;
        logic pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        // reset values
        do_reset();
        #1;
        chk("rst_audio_write", 64'(audio_write), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_active", 64'(active_clip), 64'd0);
        chk("rst_addr", 64'(rom_address), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'(IDLE));

        // 1: clip 0 at full rate, cycle-exact table
        vecs[0]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 4'b0000, 15'd0};
        vecs[1]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 4'b0001, 15'd0};
        for (int k = 0; k < 8; k++)
            vecs[2+k] = '{4'b0000, 1'b0, 1'b1, 1'b1, DW'(k), 1'b1, 1'b0, 4'b0000,
                          (k < 7) ? AW'(k + 1) : AW'(0)};
        vecs[10] = '{4'b0000, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 1'b1, 4'b0000, 15'd0};
        vecs[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 4'b0000, 15'd0};
        push_clip(0, 0, 8);
        for (int i = 0; i < 12; i++) begin
            req = vecs[i].req; stop = vecs[i].stop; write_ready = vecs[i].wr;
            #1;
            chk($sformatf("t1_aw[%0d]", i), 64'(audio_write), 64'(vecs[i].aw));
            chk($sformatf("t1_data[%0d]", i), 64'(wdata_left), 64'(vecs[i].data));
            chk($sformatf("t1_busy[%0d]", i), 64'(busy), 64'(vecs[i].busy));
            chk($sformatf("t1_done[%0d]", i), 64'(done), 64'(vecs[i].done));
            chk($sformatf("t1_pend[%0d]", i), 64'(pending), 64'(vecs[i].pend));
            chk($sformatf("t1_addr[%0d]", i), 64'(rom_address), 64'(vecs[i].addr));
            cycle();
        end
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: clip 1 with write_ready toggling 1,0,0,1
        d0 = done_cnt;
        push_clip(1, 0, 8);
        req = 4'b0010; write_ready = 1'b1;
        cycle();
        req = '0;
        n = 0;
        while (done_cnt < d0 + 1 && n < 200) begin
            write_ready = pat[n % 4];
            cycle();
            n++;
        end
        write_ready = 1'b1;
        repeat (3) cycle();
        chk("t2_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t2_busy_low", 64'(busy), 64'd0);

        // 3: req=1011 from ptr 0 plays 0,1,3; then 0|1 plays 0 first
        do_reset();
        d0 = done_cnt;
        push_clip(0, 0, 8); push_clip(1, 0, 8); push_clip(3, 0, 8);
        req = 4'b1011;
        cycle();
        req = '0;
        wait_done(d0 + 3, "t3_first");
        chk("t3_queue_empty_a", 64'(exp_q.size()), 64'd0);
        push_clip(0, 0, 8); push_clip(1, 0, 8);
        req = 4'b0011;
        cycle();
        req = '0;
        wait_done(d0 + 5, "t3_second");
        cycle();
        chk("t3_queue_empty_b", 64'(exp_q.size()), 64'd0);

        // 4: stop on the 4th sample of clip 2, clip 3 queued behind it
        d0 = done_cnt;
        push_clip(2, 0, 3); push_clip(3, 0, 8);
        req = 4'b1100;
        cycle();
        req = '0;
        w0 = wr_cnt; n = 0;
        while (wr_cnt < w0 + 3 && n < 50) begin
            cycle();
            n++;
        end
        chk("t4_three_writes", 64'(wr_cnt - w0), 64'd3);
        stop = 1'b1;
        #1;
        chk("t4_stop_no_write", 64'(audio_write), 64'd0);
        chk("t4_stop_busy", 64'(busy), 64'd1);
        chk("t4_pending_kept", 64'(pending), 64'b1000);
        cycle();
        stop = 1'b0;
        #1;
        chk("t4_after_stop_busy", 64'(busy), 64'd0);
        chk("t4_after_stop_done", 64'(done), 64'd0);
        wait_done(d0 + 1, "t4");
        cycle();
        chk("t4_done_only_clip3", 64'(done_cnt - d0), 64'd1);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // 5: re-request of the playing clip replays it
        d0 = done_cnt;
        push_clip(0, 0, 8); push_clip(0, 0, 8);
        req = 4'b0001;
        cycle();
        req = '0;
        repeat (4) cycle();
        req = 4'b0001;
        cycle();
        req = '0;
        #1;
        chk("t5_pending_self", 64'(pending), 64'b0001);
        chk("t5_active", 64'(active_clip), 64'd0);
        wait_done(d0 + 2, "t5");
        cycle();
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset mid-play discards pending work
        push_clip(0, 0, 8);
        req = 4'b0001;
        cycle();
        req = '0;
        repeat (3) cycle();
        req = 4'b0110;
        cycle();
        req = '0;
        #1;
        chk("t6_pending_before", 64'(pending), 64'b0110);
        chk("t6_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_audio_write", 64'(audio_write), 64'd0);
        chk("t6_wdata", 64'(wdata_left), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_pending", 64'(pending), 64'd0);
        chk("t6_active", 64'(active_clip), 64'd0);
        chk("t6_state", 64'(state_dbg), 64'(IDLE));
        w0 = wr_cnt;
        repeat (20) cycle();
        chk("t6_no_writes", 64'(wr_cnt - w0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
